issue_queue_n: RTL

- Parametrised issue stage between instruction decode and the Tomasulo back end.
- Buffers decoded control words in a DEPTH-entry circular queue and dispatches the head in order to one of NUM_RS ALU reservation stations, or to the load/store station.
- Gated by ROB and load/store-queue backpressure.
- Adds over the previous generation: configurable depth and station count, round-robin or fixed-priority station selection, flush, occupancy output, and fully defined (non-latching) outputs every cycle.

---
 rtl/tomasula_types_pkg.sv | 33 +++
 rtl/issue_queue_n_arbiter.sv | 38 +++
 rtl/issue_queue_n.sv | 117 +++++++++++
 3 files changed

// File: rtl/tomasula_types_pkg.sv
// Shared Tomasulo front-end types: the decoded control word, its opcode set,
// and sizing constants that decode and issue agree on.
package tomasula_types;

    localparam int IQ_DEPTH_DEFAULT = 8;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_LD  = 4'd8,
        OP_ST  = 4'd9
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [4:0]  dest_reg;
        logic [4:0]  src1_reg;
        logic [4:0]  src2_reg;
        logic [15:0] imm;
    } ctl_word;

    // Memory ops go to the load/store station rather than an ALU station.
    function automatic logic is_mem_op(input op_t op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/issue_queue_n_arbiter.sv
// Stateless station picker: round-robin from rr_ptr or fixed lowest-index
// priority, producing a one-hot grant plus its index.
module issue_rr_arbiter #(
    parameter int NUM_RS = 4,
    parameter bit RR_ARB = 1'b1,
    localparam int IW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
    input  logic [NUM_RS-1:0] req,
    input  logic [IW-1:0]     rr_ptr,
    input  logic              en,
    output logic [NUM_RS-1:0] grant,
    output logic [IW-1:0]     grant_idx,
    output logic              grant_valid
);

    // Search order position i maps to station slot(i); first free slot wins.
    function automatic int slot(input int i, input logic [IW-1:0] start);
        if (RR_ARB)
            return (int'(start) + i) % NUM_RS;
        return i;
    endfunction

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            for (int j = 0; j < NUM_RS; j++) begin
                if (en && !grant_valid && req[j] && (j == slot(i, rr_ptr))) begin
                    grant[j]    = 1'b1;
                    grant_idx   = IW'(j);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/issue_queue_n.sv
// In-order issue queue: buffers decoded words and dispatches the head to an
// ALU reservation station or the load/store station under ROB/LSQ backpressure.
module issue_queue_n
    import tomasula_types::*;
#(
    parameter int DEPTH  = IQ_DEPTH_DEFAULT,
    parameter int NUM_RS = 4,
    parameter bit RR_ARB = 1'b1,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  ctl_word           enq_word,
    input  logic [NUM_RS-1:0] rs_empty,
    output logic [NUM_RS-1:0] rs_load,
    input  logic              ldst_rs_empty,
    output logic              ldst_load,
    input  logic              rob_full,
    input  logic              ldst_q_full,
    output logic              rob_load,
    output logic [4:0]        regfile_tag1,
    output logic [4:0]        regfile_tag2,
    output ctl_word           control_o,
    output logic [CW-1:0]     occupancy
);

    localparam int IW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    ctl_word           mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [IW-1:0]     rr_ptr;

    logic              full;
    logic              empty;
    ctl_word           head_word;
    logic              head_is_mem;
    logic              can_issue;
    logic              ldst_issue;
    logic              alu_en;
    logic [NUM_RS-1:0] grant;
    logic [IW-1:0]     grant_idx;
    logic              grant_valid;
    logic              issue;
    logic              enq_fire;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign head_word   = mem[head];
    assign head_is_mem = is_mem_op(head_word.op);

    assign can_issue   = !empty && !flush && !rob_full;
    assign ldst_issue  = can_issue && head_is_mem && ldst_rs_empty && !ldst_q_full;
    assign alu_en      = can_issue && !head_is_mem;

    issue_rr_arbiter #(
        .NUM_RS (NUM_RS),
        .RR_ARB (RR_ARB)
    ) u_arb (
        .req         (rs_empty),
        .rr_ptr      (rr_ptr),
        .en          (alu_en),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign issue     = ldst_issue || grant_valid;
    assign rs_load   = grant;
    assign ldst_load = ldst_issue;
    assign rob_load  = issue;

    // No dequeue credit: a full queue refuses even while it issues.
    assign enq_ready = !full;
    assign enq_fire  = enq_valid && !full && !flush;

    assign control_o    = empty ? '0 : head_word;
    assign regfile_tag1 = empty ? '0 : head_word.src1_reg;
    assign regfile_tag2 = empty ? '0 : head_word.src2_reg;
    assign occupancy    = count;

    always_ff @(posedge clk) begin
        if (enq_fire)
            mem[tail] <= enq_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire)
                tail <= tail + 1'b1;
            if (issue)
                head <= head + 1'b1;
            if (enq_fire && !issue)
                count <= count + 1'b1;
            else if (!enq_fire && issue)
                count <= count - 1'b1;
            // Only ALU issues move the round-robin pointer.
            if (grant_valid)
                rr_ptr <= (int'(grant_idx) == NUM_RS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule
